// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: loads, stalls or flushes the fetched PC/instruction
// pair, stretches multi-cycle hazard requests with a hold counter, and keeps
// saturating stall/flush cycle counters for performance debug.

`ifndef Hazard_Signal_Width
`define Hazard_Signal_Width 4
`endif

module if_id_pipe_reg #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     HAZ_W     = `Hazard_Signal_Width,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
  parameter int unsigned     PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   if_instr,
  input  logic              if_valid,
  input  logic [1:0]        if_id_mode,
  input  logic [HAZ_W-1:0]  signal_cycle,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_instr,
  output logic              id_valid,
  output logic              hold_busy,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_STALL  = 2'b01,
    MODE_FLUSH  = 2'b10
  } mode_e;

  mode_e            held_mode;
  logic [HAZ_W-1:0] hold_cnt;

  mode_e            req_c;
  mode_e            eff_c;
  mode_e            mode_nxt_c;
  logic [HAZ_W-1:0] cnt_nxt_c;

  // Decode the request, pick the effective mode and compute the next hold state
  always_comb begin
    req_c      = MODE_NORMAL;
    eff_c      = MODE_NORMAL;
    mode_nxt_c = held_mode;
    cnt_nxt_c  = hold_cnt;

    // Flush bit dominates, so 2'b11 decodes as Flush
    if (if_id_mode[1]) begin
      req_c = MODE_FLUSH;
    end else if (if_id_mode[0]) begin
      req_c = MODE_STALL;
    end

    if (req_c != MODE_NORMAL) begin
      eff_c = req_c;
    end else if (hold_cnt != '0) begin
      eff_c = held_mode;
    end

    // A fresh request always reloads; signal_cycle of 0 behaves like 1
    if (req_c != MODE_NORMAL) begin
      mode_nxt_c = req_c;
      cnt_nxt_c  = (signal_cycle == '0) ? '0 : signal_cycle - HAZ_W'(1);
    end else if (hold_cnt != '0) begin
      cnt_nxt_c = hold_cnt - HAZ_W'(1);
    end

    if (cnt_nxt_c == '0) begin
      mode_nxt_c = MODE_NORMAL;
    end
  end

  // Hold counter, held mode and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      held_mode <= MODE_NORMAL;
      hold_busy <= 1'b0;
    end else begin
      hold_cnt  <= cnt_nxt_c;
      held_mode <= mode_nxt_c;
      hold_busy <= (cnt_nxt_c != '0);
    end
  end

  // Pipeline register update driven by the effective mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      case (eff_c)
        MODE_NORMAL: begin
          id_pc    <= if_pc;
          id_valid <= if_valid;
          id_instr <= if_valid ? if_instr : NOP_INSTR;
        end
        MODE_FLUSH: begin
          id_instr <= NOP_INSTR;
          id_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((eff_c == MODE_STALL) && !(&stall_count)) begin
        stall_count <= stall_count + PERF_W'(1);
      end
      if ((eff_c == MODE_FLUSH) && !(&flush_count)) begin
        flush_count <= flush_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Testbench for if_id_pipe_reg: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.

module tb_if_id_pipe_reg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned HAZ_W   = 4;
  localparam int unsigned PERF_W  = 32;
  localparam int unsigned PERF_WS = 3;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam longint      MAX_BIG = 64'h00000000FFFFFFFF;
  localparam longint      MAX_SML = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_instr;
  logic              if_valid;
  logic [1:0]        if_id_mode;
  logic [HAZ_W-1:0]  signal_cycle;

  logic [XLEN-1:0]    id_pc,    id_pc_s;
  logic [XLEN-1:0]    id_instr, id_instr_s;
  logic               id_valid, id_valid_s;
  logic               hold_busy, hold_busy_s;
  logic [PERF_W-1:0]  stall_count, flush_count;
  logic [PERF_WS-1:0] stall_count_s, flush_count_s;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  if_id_pipe_reg #(.XLEN(XLEN), .HAZ_W(HAZ_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .if_id_mode(if_id_mode), .signal_cycle(signal_cycle),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .hold_busy(hold_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run
  if_id_pipe_reg #(.XLEN(XLEN), .HAZ_W(HAZ_W), .PERF_W(PERF_WS)) dut_s (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .if_id_mode(if_id_mode), .signal_cycle(signal_cycle),
    .id_pc(id_pc_s), .id_instr(id_instr_s), .id_valid(id_valid_s), .hold_busy(hold_busy_s),
    .stall_count(stall_count_s), .flush_count(flush_count_s)
  );

  // Behavioural model: a request at cycle t covers cycles t .. t+N-1
  int          t;
  int          held_end;
  int          held_kind;   // 0 normal, 1 stall, 2 flush
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_busy;
  longint      m_stall, m_flush, m_stall_s, m_flush_s;

  task automatic model_reset();
    held_end  = -1;
    held_kind = 0;
    m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_busy = 1'b0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  task automatic model_step();
    int req, eff, n;
    if (rst) begin
      model_reset();
      t++;
      return;
    end
    req = if_id_mode[1] ? 2 : (if_id_mode[0] ? 1 : 0);
    n   = (signal_cycle == 0) ? 1 : int'(signal_cycle);
    if (req != 0) begin
      eff       = req;
      held_kind = req;
      held_end  = t + n - 1;
    end else if (t <= held_end) begin
      eff = held_kind;
    end else begin
      eff = 0;
    end
    if (eff == 0) begin
      m_pc    = if_pc;
      m_valid = if_valid;
      m_instr = if_valid ? if_instr : NOP;
    end else if (eff == 2) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
    if (eff == 1) begin
      if (m_stall   < MAX_BIG) m_stall++;
      if (m_stall_s < MAX_SML) m_stall_s++;
    end
    if (eff == 2) begin
      if (m_flush   < MAX_BIG) m_flush++;
      if (m_flush_s < MAX_SML) m_flush_s++;
    end
    m_busy = (held_end > t);
    t++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("id_pc",         64'(id_pc),         64'(m_pc));
      check("id_instr",      64'(id_instr),      64'(m_instr));
      check("id_valid",      64'(id_valid),      64'(m_valid));
      check("hold_busy",     64'(hold_busy),     64'(m_busy));
      check("stall_count",   64'(stall_count),   64'(m_stall));
      check("flush_count",   64'(flush_count),   64'(m_flush));
      check("id_pc_s",       64'(id_pc_s),       64'(m_pc));
      check("id_valid_s",    64'(id_valid_s),    64'(m_valid));
      check("hold_busy_s",   64'(hold_busy_s),   64'(m_busy));
      check("stall_count_s", 64'(stall_count_s), 64'(m_stall_s));
      check("flush_count_s", 64'(flush_count_s), 64'(m_flush_s));
    end
  end

  // Apply one cycle of inputs (called just after a rising edge)
  task automatic step(input logic [1:0] mode, input int sc, input logic [31:0] pc,
                      input logic [31:0] ins, input logic v, input logic r);
    if_id_mode   = mode;
    signal_cycle = HAZ_W'(sc);
    if_pc        = pc;
    if_instr     = ins;
    if_valid     = v;
    rst          = r;
    if (r) model_reset();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    t = 0;
    rst = 1'b1; if_id_mode = 2'b00; signal_cycle = '0;
    if_pc = '0; if_instr = '0; if_valid = 1'b0;
    model_reset();
    @(posedge clk); model_step(); #1;
    check("reset_pc",    64'(id_pc),    64'h0);
    check("reset_instr", 64'(id_instr), 64'(NOP));
    check("reset_valid", 64'(id_valid), 64'h0);
    chk_en = 1'b1;

    // Normal load
    step(2'b00, 1, 32'h100, 32'h00500093, 1'b1, 1'b0);
    check("load_pc",    64'(id_pc),    64'h100);
    check("load_instr", 64'(id_instr), 64'h00500093);
    check("load_valid", 64'(id_valid), 64'h1);
    check("load_stall", 64'(stall_count), 64'h0);

    // Stall for 3 cycles
    step(2'b01, 3, 32'h200, 32'h11111111, 1'b1, 1'b0);
    check("st1_pc",   64'(id_pc), 64'h100);
    check("st1_busy", 64'(hold_busy), 64'h1);
    step(2'b00, 1, 32'h104, 32'h00a00113, 1'b1, 1'b0);
    check("st2_busy", 64'(hold_busy), 64'h1);
    step(2'b00, 1, 32'h104, 32'h00a00113, 1'b1, 1'b0);
    check("st3_pc",    64'(id_pc), 64'h100);
    check("st3_busy",  64'(hold_busy), 64'h0);
    check("st3_count", 64'(stall_count), 64'd3);
    step(2'b00, 1, 32'h104, 32'h00a00113, 1'b1, 1'b0);
    check("st4_pc",    64'(id_pc), 64'h104);
    check("st4_instr", 64'(id_instr), 64'h00a00113);

    // Single-cycle flush
    step(2'b10, 1, 32'h300, 32'h22222222, 1'b1, 1'b0);
    check("fl_instr", 64'(id_instr), 64'(NOP));
    check("fl_valid", 64'(id_valid), 64'h0);
    check("fl_pc",    64'(id_pc), 64'h104);
    check("fl_count", 64'(flush_count), 64'd1);
    check("fl_busy",  64'(hold_busy), 64'h0);

    // Mode 2'b11 acts as a two-cycle flush
    step(2'b11, 2, 32'h108, 32'h33333333, 1'b1, 1'b0);
    step(2'b00, 1, 32'h108, 32'h33333333, 1'b1, 1'b0);
    check("f11_valid", 64'(id_valid), 64'h0);
    check("f11_flush", 64'(flush_count), 64'd3);
    check("f11_stall", 64'(stall_count), 64'd3);
    step(2'b00, 1, 32'h108, 32'h33333333, 1'b1, 1'b0);
    check("f11_load", 64'(id_pc), 64'h108);

    // Flush overriding a held stall
    step(2'b01, 4, 32'h10c, 32'h44444444, 1'b1, 1'b0);
    step(2'b10, 1, 32'h10c, 32'h44444444, 1'b1, 1'b0);
    check("ovr_busy",  64'(hold_busy), 64'h0);
    check("ovr_stall", 64'(stall_count), 64'd4);
    check("ovr_flush", 64'(flush_count), 64'd4);
    step(2'b00, 1, 32'h10c, 32'h44444444, 1'b1, 1'b0);
    check("ovr_load",  64'(id_pc), 64'h10c);

    // Asynchronous reset in the middle of a stall hold
    step(2'b01, 5, 32'h110, 32'h55555555, 1'b1, 1'b0);
    step(2'b00, 1, 32'h110, 32'h55555555, 1'b1, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", 64'(id_valid), 64'h0);
    check("arst_instr", 64'(id_instr), 64'(NOP));
    check("arst_busy",  64'(hold_busy), 64'h0);
    check("arst_stall", 64'(stall_count), 64'h0);
    @(posedge clk); model_step(); #1;
    step(2'b00, 1, 32'h114, 32'h66666666, 1'b1, 1'b0);
    check("arst_load", 64'(id_pc), 64'h114);

    // Saturation on the narrow instance
    step(2'b01, 10, 32'h118, 32'h77777777, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(2'b00, 1, 32'h118, 32'h77777777, 1'b1, 1'b0);
    check("sat_small", 64'(stall_count_s), 64'd7);
    check("sat_big",   64'(stall_count),   64'd10);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [1:0] md;
      r  = int'($urandom_range(0, 9));
      md = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      step(md, int'($urandom_range(0, 6)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 149) == 0));
    end
    step(2'b00, 1, 32'h0, 32'h0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- IF/ID pipeline register that receives the hazard detection unit's if_id_mode and signal_cycle.
- Each cycle it loads, holds, or flushes the fetched PC/instruction pair.
- A signal_cycle value greater than 1 extends a stall or flush over several cycles using an internal hold counter.
- Exposes saturating stall/flush event counters for performance debug.
- Sits between the fetch stage and the decode stage.

Parameters:
- XLEN, 32, width of PC and instruction.
- HAZ_W, `Hazard_Signal_Width, width of signal_cycle.
- NOP_INSTR, 32'h00000013, instruction injected on flush (addi x0,x0,0).
- PERF_W, 32, width of each performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_pc  input  XLEN  PC of the fetched instruction.
- if_instr  input  XLEN  fetched instruction word.
- if_valid  input  1  fetch output is valid.
- if_id_mode  input  2  `Normal=2'b00, `Stall=2'b01, `Flush=2'b10; 2'b11 is legal and means Flush.
- signal_cycle  input  HAZ_W  number of cycles the current request applies; 0 is treated as 1.
- id_pc  output  XLEN  registered PC to decode.
- id_instr  output  XLEN  registered instruction to decode.
- id_valid  output  1  registered valid to decode.
- hold_busy  output  1  a multi-cycle request is being extended (hold_cnt != 0).
- stall_count  output  PERF_W  cycles spent in effective Stall, saturating.
- flush_count  output  PERF_W  cycles spent in effective Flush, saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-hold):
  - id_pc=0, id_instr=NOP_INSTR, id_valid=0.
  - hold_cnt=0, held_mode=`Normal, hold_busy=0.
  - stall_count=0, flush_count=0.
- Request decode (combinational):
  - req = Flush if if_id_mode[1]; else Stall if if_id_mode[0]; else Normal.
- Effective mode (combinational):
  - If req != Normal: eff = req.
  - Else if hold_cnt != 0: eff = held_mode.
  - Else: eff = Normal.
- Hold counter (on each clock edge):
  - If req != Normal: held_mode <= req; hold_cnt <= max(signal_cycle,1) - 1. A new request always reloads the counter, so a fresh request overrides an in-progress hold of either kind.
  - Else if hold_cnt != 0: hold_cnt <= hold_cnt - 1.
  - When hold_cnt reaches 0, held_mode returns to `Normal.
  - A request with signal_cycle = N therefore applies for exactly N consecutive cycles: the request cycle plus N-1 held cycles.
- Register update (on each clock edge, by eff):
  - Normal: id_pc <= if_pc; id_valid <= if_valid; id_instr <= if_valid ? if_instr : NOP_INSTR.
  - Stall: all id_* outputs hold their values.
  - Flush: id_instr <= NOP_INSTR; id_valid <= 0; id_pc holds.
- Latency: one cycle from IF inputs to ID outputs in Normal mode.
- Performance counters:
  - stall_count += 1 each cycle eff == Stall; flush_count += 1 each cycle eff == Flush.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - Stall and flush bits both set: Flush wins.
  - Flush arriving during a held Stall: immediately takes over and reloads the counter.
  - Stall arriving during a held Flush: also reloads (the requester is authoritative).
- hold_busy is purely hold_cnt != 0. It is 0 during a request cycle with signal_cycle ≤ 1.

Test Plan:
- Reset then Normal with if_pc=0x100, if_instr=0x00500093, if_valid=1 -> next cycle id_pc=0x100, id_instr=0x00500093, id_valid=1; stall_count=flush_count=0.
- Registers loaded with 0x100; if_id_mode=`Stall, signal_cycle=3 for one cycle, then Normal with if_pc=0x104 -> id_* stay at the 0x100 values for 3 edges and load 0x104 on the 4th; hold_busy=1 for 2 cycles; stall_count=3.
- if_id_mode=`Flush, signal_cycle=1 -> id_instr=0x00000013, id_valid=0, id_pc unchanged; flush_count=1; hold_busy stays 0.
- if_id_mode=2'b11, signal_cycle=2 -> treated as Flush for 2 cycles; flush_count=2, stall_count unchanged.
- Stall with signal_cycle=4; on the 2nd cycle request Flush with signal_cycle=1 -> that cycle flushes, hold_cnt reloads to 0, next cycle Normal; stall_count=1, flush_count=1.
- Stall with signal_cycle=5; assert rst during the 3rd cycle -> outputs immediately return to reset values, hold_busy=0; after release, Normal loading resumes on the first edge.
- Force stall_count to all-ones, then apply a further Stall -> stall_count remains all-ones.
